fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..16).
REQ-002 SHALL have parameter PC_BITS, default 16, width of the PC and of the instruction word.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  branch redirect; discard all queued entries.
REQ-006 in_valid  input  1  fetch stage presents an instruction.
REQ-007 in_pc  input  PC_BITS  PC of the presented instruction.
REQ-008 in_instr  input  PC_BITS  presented instruction word.
REQ-009 in_ready  output  1  queue accepts a push; fetch stall = !in_ready.
REQ-010 out_valid  output  1  head entry available to decode.
REQ-011 out_pc  output  PC_BITS  PC of the head entry.
REQ-012 out_instr  output  PC_BITS  instruction of the head entry.
REQ-013 out_ready  input  1  decode consumes the head entry.
REQ-014 count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-015 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL equal (count != DEPTH) && !flush && rst_n, combinationally; no pass-through when full, even if a pop occurs in the same cycle.
REQ-017 out_valid SHALL equal (count != 0) && !flush (see REQ-031 for bypass).
REQ-018 out_pc/out_instr SHALL show the entry at the read pointer; their value is unspecified when out_valid=0.
REQ-019 Entries SHALL be delivered in strict push order, pc and instr kept paired.
REQ-020 Push-to-out_valid latency SHALL be 1 cycle: an entry pushed in cycle N is visible at cycle N+1 if it is at the head.
REQ-021 Write and read pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-022 count SHALL increment on push-only, decrement on pop-only, and hold on simultaneous push+pop.
REQ-023 A simultaneous push and pop with count=1 SHALL leave count=1 with the new entry at the head next cycle.
REQ-024 On flush, next cycle count=0 and both pointers=0; any push or pop presented in the flush cycle SHALL have no effect.
REQ-025 flush held for several cycles SHALL keep the queue empty, in_ready=0 and out_valid=0 throughout.
REQ-026 in_valid while in_ready=0 SHALL be ignored; fetch holds its data, and no error is flagged.

Reset
REQ-027 While rst_n=0 at a rising edge: count=0, pointers=0, all storage entries=0; reset SHALL take priority over flush, push and pop.
REQ-028 While rst_n=0, in_ready=0 and out_valid=0; in the first cycle after release, in_ready=1, out_valid=0 and count=0.
REQ-029 A reset mid-operation SHALL discard all entries, with no entry delivered after release.

Configuration
REQ-030 Macro FETCH_QUEUE_BYPASS_EN SHALL select empty-queue bypass.
REQ-031 With the macro defined: when count=0 and !flush, out_valid=in_valid, out_pc=in_pc and out_instr=in_instr combinationally; if out_ready=1 the entry is consumed and not stored (count stays 0), otherwise it is stored as a normal push.
REQ-032 Without the macro: no combinational path from in_* to out_*; the 1-cycle latency of REQ-020 applies.

Verification
REQ-033 After reset, push pc=0x0000/instr=0x1111, pc=0x0004/instr=0x2222 with out_ready=0 -> count=2, out_pc=0x0000, out_instr=0x1111; pop twice -> outputs in order, then count=0.
REQ-034 Push 4 entries with out_ready=0 -> count=4, in_ready=0; assert in_valid with pc=0x0010 -> ignored; pop one and push pc=0x0010 -> delivered after pc=0x000C.
REQ-035 Fill to 3, then assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0; push pc=0x0040 -> it is the next entry out.
REQ-036 Stream 10 entries with push+pop every cycle -> pointers wrap, count stays 1, PCs 0x0000..0x0024 emerge in order with 1-cycle latency (bypass: 0 latency, count=0).
REQ-037 Fill to 2, drive rst_n=0 for 1 cycle -> count=0, out_valid=0 after release, in_ready=1 in the first released cycle.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch stage, the fetch queue and decode.
//   in_valid/in_pc/in_instr/in_ready  : push side (fetch -> queue)
//   out_valid/out_pc/out_instr/out_ready : pop side (queue -> decode)
//   flush : branch redirect, empties the queue
//   count : current queue occupancy, 0..DEPTH
// Modports: slave = the queue itself, master = the surrounding pipeline.
interface fetch_queue_if #(
   parameter int DEPTH   = 4,
   parameter int PC_BITS = 16
) ();
   localparam int CW = $clog2(DEPTH) + 1;

   logic               flush;
   logic               in_valid;
   logic [PC_BITS-1:0] in_pc;
   logic [PC_BITS-1:0] in_instr;
   logic               in_ready;
   logic               out_valid;
   logic [PC_BITS-1:0] out_pc;
   logic [PC_BITS-1:0] out_instr;
   logic               out_ready;
   logic [CW-1:0]      count;

   modport slave (
      input  flush, in_valid, in_pc, in_instr, out_ready,
      output in_ready, out_valid, out_pc, out_instr, count
   );

   modport master (
      output flush, in_valid, in_pc, in_instr, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, count
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: a DEPTH-entry FIFO of {pc, instr} pairs sitting
// between fetch and decode.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset, beats flush/push/pop
//   fq    : fetch_queue_if.slave (push side, pop side, flush, count)
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let an empty queue pass
// the incoming instruction straight to decode in the same cycle.
module fetch_queue #(
   parameter int DEPTH   = 4,
   parameter int PC_BITS = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   fetch_queue_if.slave  fq
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PC_BITS-1:0] mem_pc    [DEPTH];
   logic [PC_BITS-1:0] mem_instr [DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [CW-1:0]      count_q;

   logic full, empty, push, pop, wr_en, rd_en;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // No pass-through when full: a same-cycle pop does not open a slot.
   assign fq.in_ready = !full && !fq.flush && rst_n;

`ifdef FETCH_QUEUE_BYPASS_EN
   // Empty queue forwards the fetch stage directly to decode.
   assign fq.out_valid = empty ? (fq.in_valid && !fq.flush && rst_n)
                               : (!fq.flush && rst_n);
   assign fq.out_pc    = empty ? fq.in_pc    : mem_pc[rd_ptr];
   assign fq.out_instr = empty ? fq.in_instr : mem_instr[rd_ptr];
`else
   assign fq.out_valid = !empty && !fq.flush && rst_n;
   assign fq.out_pc    = mem_pc[rd_ptr];
   assign fq.out_instr = mem_instr[rd_ptr];
`endif

   assign fq.count = count_q;

   assign push = fq.in_valid && fq.in_ready;
   assign pop  = fq.out_valid && fq.out_ready;

   // A pop while empty can only be a bypass consumption; that entry is
   // never stored. Without bypass, empty && pop cannot happen.
   assign wr_en = push && !(empty && pop);
   assign rd_en = pop && !empty;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_pc[i]    <= '0;
            mem_instr[i] <= '0;
         end
      end else if (fq.flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_en) begin
            mem_pc[wr_ptr]    <= fq.in_pc;
            mem_instr[wr_ptr] <= fq.in_instr;
            wr_ptr            <= wr_ptr + PW'(1);
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end
endmodule
